// File: rtl/diff_requantizer_if.sv
// Subtractor-to-requantizer stream bundle: strobe-qualified input plus valid/ready output.
// The master modport belongs to the driver/consumer side; the slave modport belongs to the requantizer.
interface diff_requantizer_if #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16
);
  logic              in_strobe;
  logic [IN_W-1:0]   in_sum;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output in_strobe, in_sum, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_strobe, in_sum, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/diff_requantizer.sv
// Round-shift and saturate the subtractor difference, then buffer it. Strobe to FIFO head takes 2 cycles.
// Backpressure: out_ready stalls the FIFO head; a sample arriving at a full FIFO with no pop is dropped and counted.
module diff_requantizer #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16,
  parameter int DEPTH = 8
) (
  input  logic                   M100CLK,
  input  logic                   reset,
  diff_requantizer_if.slave      bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            sat_count,
  output logic [15:0]            drop_count,
  output logic                   overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_HI = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_LO = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // One extra bit of headroom so the rounding constant can never wrap the sum.
  logic signed [IN_W:0] w_sext;
  logic signed [IN_W:0] w_rnd;
  logic signed [IN_W:0] r_s1_val;
  logic                 r_s1_vld;

  logic [OUT_W-1:0] w_sat_dat;
  logic             w_clip;

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [15:0]      r_sat_cnt;
  logic [15:0]      r_drop_cnt;
  logic             r_ovf;

  logic w_vld;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_sext = {bus.in_sum[IN_W-1], bus.in_sum};
  assign w_rnd  = w_sext + $signed(RND);

  always_comb begin
    w_sat_dat = r_s1_val[OUT_W-1:0];
    w_clip    = 1'b0;
    if (r_s1_val > SAT_HI) begin
      w_sat_dat = {1'b0, {(OUT_W-1){1'b1}}};
      w_clip    = 1'b1;
    end else if (r_s1_val < SAT_LO) begin
      w_sat_dat = {1'b1, {(OUT_W-1){1'b0}}};
      w_clip    = 1'b1;
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_vld  = (r_level != '0);
  assign w_pop  = w_vld && bus.out_ready;
  assign w_push = r_s1_vld && ((r_level != FULL) || w_pop);
  assign w_drop = r_s1_vld && !w_push;

  always_ff @(posedge M100CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_sat_dat;
    end
  end

  always_ff @(posedge M100CLK) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_val   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_s1_vld <= bus.in_strobe;
      if (bus.in_strobe) begin
        r_s1_val <= w_rnd >>> SHIFT;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (r_s1_vld && w_clip && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.out_valid = w_vld;
  assign bus.out_data  = w_vld ? r_mem[r_rd_ptr] : '0;
  assign fifo_level    = r_level;
  assign sat_count     = r_sat_cnt;
  assign drop_count    = r_drop_cnt;
  assign overflow      = r_ovf;
endmodule

// File: tb/tb_diff_requantizer.sv
// Directed bench for diff_requantizer: expected samples are queued at strobe time and
// consumed by an independent monitor whenever the output handshake fires.
module tb_diff_requantizer;
  logic        M100CLK = 1'b0;
  logic        reset;
  logic [3:0]  fifo_level;
  logic [15:0] sat_count;
  logic [15:0] drop_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  diff_requantizer_if bus ();

  diff_requantizer dut (
    .M100CLK    (M100CLK),
    .reset      (reset),
    .bus        (bus),
    .fifo_level (fifo_level),
    .sat_count  (sat_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 M100CLK = ~M100CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge M100CLK);
    #1;
  endtask

  // Issue one strobe; keep=0 marks a sample the bench expects to be dropped or discarded.
  task automatic send(input logic [32:0] v, input logic [15:0] e, input bit keep);
    bus.in_strobe = 1'b1;
    bus.in_sum    = v;
    if (keep) exp_q.push_back(e);
    tick();
    bus.in_strobe = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain timeout actual=%0d left expected=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  always @(negedge M100CLK) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", bus.out_data);
      end else begin
        chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.in_strobe = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_level", 32'(fifo_level),    32'd0);
    chk("rst_sat",   32'(sat_count),     32'd0);
    chk("rst_drop",  32'(drop_count),    32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);
    reset = 1'b0;
    tick();

    // 1: rounding and two-cycle latency
    bus.out_ready = 1'b1;
    send(33'h0_0001_8000, 16'h0002, 1'b1);
    chk("lat_k1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_k2_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_k2_data",  32'(bus.out_data),  32'h0002);
    send(33'h0_0001_7FFF, 16'h0001, 1'b1);
    wait_drain("t1");
    chk("t1_sat", 32'(sat_count), 32'd0);

    // 2: positive and negative clipping
    send(33'h0_FFFF_FFFF, 16'h7FFF, 1'b1);
    tick();
    chk("t2_sat1", 32'(sat_count), 32'd1);
    send(33'h1_0000_0000, 16'h8000, 1'b1);
    tick();
    chk("t2_sat2", 32'(sat_count), 32'd2);
    wait_drain("t2");

    // 3: negative rounding toward +inf
    send(33'h1_FFFF_0000, 16'hFFFF, 1'b1);
    send(33'h1_FFFF_8000, 16'h0000, 1'b1);
    wait_drain("t3");
    chk("t3_sat", 32'(sat_count), 32'd2);

    // 4: overfill while stalled, then drain
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send(33'(i) << 16, 16'(i), i <= 8);
    repeat (2) tick();
    chk("t4_level", 32'(fifo_level),    32'd8);
    chk("t4_drop",  32'(drop_count),    32'd2);
    chk("t4_ovf",   32'(overflow),      32'd1);
    chk("t4_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_head",  32'(bus.out_data),  32'd1);
    bus.out_ready = 1'b1;
    repeat (7) tick();
    chk("t4_last_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_last_level", 32'(fifo_level),    32'd1);
    tick();
    chk("t4_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_empty_data",  32'(bus.out_data),  32'd0);
    wait_drain("t4");

    // 5: full FIFO with simultaneous push and pop every cycle
    bus.out_ready = 1'b0;
    for (int i = 20; i < 28; i++) send(33'(i) << 16, 16'(i), 1'b1);
    repeat (2) tick();
    chk("t5_full", 32'(fifo_level), 32'd8);
    send(33'(28) << 16, 16'd28, 1'b1);
    bus.out_ready = 1'b1;
    chk("t5_level_start", 32'(fifo_level), 32'd8);
    for (int i = 29; i < 36; i++) begin
      send(33'(i) << 16, 16'(i), 1'b1);
      chk("t5_level", 32'(fifo_level), 32'd8);
    end
    chk("t5_drop", 32'(drop_count), 32'd2);
    wait_drain("t5");

    // 6: reset mid-burst discards buffered and in-flight samples
    bus.out_ready = 1'b0;
    send(33'(40) << 16, 16'd40, 1'b1);
    send(33'(41) << 16, 16'd41, 1'b1);
    send(33'(42) << 16, 16'd42, 1'b1);
    send(33'(43) << 16, 16'd43, 1'b0);
    chk("t6_queued", 32'(fifo_level), 32'd3);
    exp_q.delete();
    reset         = 1'b1;
    bus.in_strobe = 1'b1;
    bus.in_sum    = 33'(44) << 16;
    tick();
    bus.in_strobe = 1'b0;
    chk("t6_level", 32'(fifo_level),    32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_data",  32'(bus.out_data),  32'd0);
    chk("t6_sat",   32'(sat_count),     32'd0);
    chk("t6_drop",  32'(drop_count),    32'd0);
    chk("t6_ovf",   32'(overflow),      32'd0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("t6_no_ghost", 32'(bus.out_valid), 32'd0);
    send(33'(5) << 16, 16'd5, 1'b1);
    wait_drain("t6");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
